// File: rtl/pulse_channel.sv
// rtl/pulse_channel.sv - square-wave tone channel with duty sequencer, envelope and length counter
module pulse_channel #(
  parameter int N        = 4,
  parameter int PERIOD_W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trigger,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          duty,
  input  logic [N-1:0]        init_vol,
  input  logic                env_dir,
  input  logic [2:0]          env_pace,
  input  logic                len_en,
  input  logic [5:0]          len_load,
  input  logic                env_tick,
  input  logic                len_tick,
  output logic [N-1:0]        out,
  output logic                active
);

  logic [PERIOD_W-1:0] timer_cnt;
  logic [2:0]          step;
  logic [N-1:0]        volume;
  logic [2:0]          env_cnt;
  logic [5:0]          len_cnt;
  logic [7:0]          pattern;
  logic                dac_on;
  logic                timer_wrap;

  always_comb begin
    pattern = 8'b00000001;
    case (duty)
      2'b00: pattern = 8'b00000001;
      2'b01: pattern = 8'b10000001;
      2'b10: pattern = 8'b10000111;
      2'b11: pattern = 8'b01111110;
      default: pattern = 8'b00000001;
    endcase
  end

  // A zero initial volume that can only fall is treated as a powered-down DAC.
  assign dac_on     = (init_vol != '0) || env_dir;
  assign timer_wrap = (timer_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      active    <= 1'b0;
      timer_cnt <= '0;
      step      <= '0;
      volume    <= '0;
      env_cnt   <= '0;
      len_cnt   <= '0;
    end else begin
      out <= (active && pattern[step]) ? volume : '0;
      if (trigger) begin
        // Strobes landing on a trigger cycle are intentionally discarded.
        if (dac_on) begin
          active    <= 1'b1;
          timer_cnt <= period;
          step      <= '0;
          volume    <= init_vol;
          env_cnt   <= env_pace;
          len_cnt   <= len_load;
        end else begin
          active <= 1'b0;
        end
      end else if (active) begin
        if (timer_wrap) begin
          timer_cnt <= period;
          step      <= step + 3'd1;
        end else begin
          timer_cnt <= timer_cnt + 1'b1;
        end

        if (env_tick && (env_pace != 3'd0)) begin
          if (env_cnt <= 3'd1) begin
            env_cnt <= env_pace;
            if (env_dir) begin
              if (volume != '1) volume <= volume + 1'b1;
            end else begin
              if (volume != '0) volume <= volume - 1'b1;
            end
          end else begin
            env_cnt <= env_cnt - 3'd1;
          end
        end

        if (len_tick && len_en) begin
          if (len_cnt == 6'd63) active <= 1'b0;
          else                  len_cnt <= len_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: doc/pulse_channel.md
Name: pulse_channel

Overview:
- Square-wave tone generator; produces one N-bit channel sample for the downstream multi-channel wave adder. Four instances feed its packed channel bus.
- Contains a programmable frequency timer, 8-step duty sequencer, volume envelope and length counter.
- Envelope and length steps are clocked by strobes from an external frame sequencer.

Parameters:
- N, 4, output / volume width in bits.
- PERIOD_W, 11, width of the frequency period register.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- trigger  input  1  one-cycle start/restart strobe.
- period  input  PERIOD_W  timer reload value; step rate = clk / (2^PERIOD_W - period).
- duty  input  2  duty pattern select.
- init_vol  input  N  volume loaded on trigger.
- env_dir  input  1  envelope direction: 1 = up, 0 = down.
- env_pace  input  3  env_tick strobes per volume step; 0 = envelope frozen.
- len_en  input  1  enable length cut-off.
- len_load  input  6  initial length count.
- env_tick  input  1  envelope strobe, one cycle wide.
- len_tick  input  1  length strobe, one cycle wide.
- out  output  N  channel sample to the wave adder.
- active  output  1  channel is sounding.

Behaviour:
- Reset (async, rst_n low): out, active, timer_cnt, step, volume, env_cnt and len_cnt are all 0. Release is synchronous to clk.
- Trigger:
  - If init_vol == 0 and env_dir == 0 ("DAC off"), trigger is ignored: active stays/goes 0.
  - Otherwise, next edge: active <= 1, timer_cnt <= period, step <= 0, volume <= init_vol, env_cnt <= env_pace, len_cnt <= len_load.
  - Retrigger while active restarts all of the above.
- Timer (only while active):
  - Each clk, timer_cnt <= timer_cnt + 1.
  - When timer_cnt == 2^PERIOD_W - 1: timer_cnt <= period, and step <= step + 1 (3-bit, wraps 7 -> 0).
  - period is sampled only at reload, so changes take effect at the next reload.
  - Timer and step hold while inactive.
- Duty patterns (bit[step]):
  - 00 = 8'b00000001
  - 01 = 8'b10000001
  - 10 = 8'b10000111
  - 11 = 8'b01111110
- Envelope (active, env_tick, env_pace != 0):
  - If env_cnt <= 1: env_cnt <= env_pace and volume steps ±1. Up saturates at 2^N-1; down saturates at 0.
  - Else env_cnt <= env_cnt - 1.
  - env_pace == 0: volume frozen, env_cnt untouched.
  - Volume reaching 0 does not clear active.
- Length (active, len_tick, len_en):
  - If len_cnt == 63: active <= 0.
  - Else len_cnt <= len_cnt + 1.
  - Sound lasts 64 - len_load len_ticks. len_en = 0: length ignored.
- out is registered, 1-cycle latency: out <= (active && pattern[step]) ? volume : 0, computed from current-cycle register values.
- Priority in the same cycle: trigger > len_tick/env_tick. A strobe coincident with trigger is dropped.
- Reset mid-note: immediate silence (out = 0, active = 0).

Test Plan:
- Reset: rst_n low mid-note with out = 9 -> out = 0 and active = 0 asynchronously, before the next edge. Released with no trigger -> out stays 0.
- Timing: period = 2044, duty = 10, init_vol = 9, env_pace = 0, len_en = 0, trigger -> step advances every 4 clk. out alternates 9 for 16 clk (steps 7, 0, 1, 2) and 0 for 16 clk (32-clk period). Retrigger -> step 0, out = 9 one cycle after the retrigger edge.
- Envelope up: init_vol = 13, env_dir = 1, env_pace = 2, duty = 11 -> volume 14 after 2 env_ticks, 15 after 4, stays 15 thereafter. Down from init_vol = 1, pace = 1 -> 0 after 1 tick, active stays 1.
- Length: len_en = 1, len_load = 62 -> active = 1 after 1 len_tick, 0 after 2 len_ticks, out = 0 from then. len_en = 0 -> still active after 100 len_ticks.
- DAC off and priority: init_vol = 0, env_dir = 0, trigger -> active stays 0. Trigger coincident with env_tick -> volume = init_vol, env_cnt = env_pace (tick lost).
- Duty sweep: period = 2047 (1 clk/step), duty 00/01/11 -> out high for exactly 1/2/6 of every 8 clk, at steps {0}, {0,7}, {1..6}.
